// File: rtl/wave_capture_ctrl.sv
// Ping-pong waveform capture sequencer: arms on a rising zero-crossing or timeout,
// fills one bank of 2^ADDR_W samples, then swaps banks on the next vsync rising edge.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ARM     | waiting for rising zero-crossing or trigger timeout
//   CAPTURE | writing one sample per accepted strobe into the write bank
//   DONE    | bank full; waiting for vsync rise to hand it to the display
module wave_capture_ctrl #(
  parameter int ADDR_W       = 8,
  parameter int TRIG_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              new_sample,
  input  logic [15:0]       sample,
  input  logic              vsync,
  input  logic              capture_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic              frame_swapped,
  output logic [1:0]        state
);

  localparam int CNT_W = (TRIG_TIMEOUT > 0) ? $clog2(TRIG_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(TRIG_TIMEOUT);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {
    ARM     = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t             st, st_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               prev_sign, vsync_q;
  logic               wr_en_nxt, bank_nxt, fs_nxt;
  logic [ADDR_W-1:0]  addr_nxt;
  logic [7:0]         data_nxt;
  logic               vsync_rise, crossing;
  logic [7:0]         pcm8;

  assign vsync_rise = vsync & ~vsync_q;
  assign crossing   = prev_sign & ~sample[15];
  assign pcm8       = {~sample[15], sample[14:8]};
  assign state      = st;

  always_comb begin
    st_nxt    = st;
    cnt_nxt   = cnt;
    wr_en_nxt = 1'b0;
    addr_nxt  = wr_addr;
    data_nxt  = wr_data;
    bank_nxt  = wr_bank;
    fs_nxt    = 1'b0;
    case (st)
      ARM: begin
        if (new_sample && capture_en) begin
          if (crossing || cnt == CNT_MAX) begin
            st_nxt    = CAPTURE;
            cnt_nxt   = '0;
            wr_en_nxt = 1'b1;
            addr_nxt  = '0;
            data_nxt  = pcm8;
          end else begin
            // cnt < CNT_MAX here, so the increment saturates naturally at the trigger point
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      CAPTURE: begin
        if (new_sample) begin
          wr_en_nxt = 1'b1;
          addr_nxt  = wr_addr + ADDR_W'(1);
          data_nxt  = pcm8;
          if (wr_addr == ADDR_LAST - ADDR_W'(1)) st_nxt = DONE;
        end
      end
      DONE: begin
        if (vsync_rise) begin
          bank_nxt = ~wr_bank;
          fs_nxt   = 1'b1;
          st_nxt   = ARM;
        end
      end
      default: st_nxt = ARM;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st            <= ARM;
      cnt           <= '0;
      prev_sign     <= 1'b0;
      vsync_q       <= 1'b0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b1;
      frame_swapped <= 1'b0;
    end else begin
      st            <= st_nxt;
      cnt           <= cnt_nxt;
      vsync_q       <= vsync;
      if (new_sample) prev_sign <= sample[15];
      wr_en         <= wr_en_nxt;
      wr_addr       <= addr_nxt;
      wr_data       <= data_nxt;
      wr_bank       <= bank_nxt;
      rd_bank       <= ~bank_nxt;
      frame_swapped <= fs_nxt;
    end
  end

endmodule

// File: tb/tb_wave_capture_ctrl.sv
// Bench for wave_capture_ctrl (ADDR_W=3, TRIG_TIMEOUT=4): directed scenarios plus a
// randomized run compared cycle by cycle against a sample-level behavioural model.
module tb_wave_capture_ctrl;

  localparam int ADDR_W = 3;
  localparam int TO     = 4;
  localparam int NB     = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              new_sample = 1'b0;
  logic [15:0]       sample = '0;
  logic              vsync = 1'b0;
  logic              capture_en = 1'b1;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_bank, rd_bank, frame_swapped;
  logic [1:0]        state;

  int errors = 0;
  int checks = 0;

  // model: 0 = arming, 1 = capturing, 2 = bank full
  int   m_mode, m_cnt, m_addr;
  bit   m_prev, m_vq, m_we, m_bank, m_fs;
  logic [7:0] m_data;

  wave_capture_ctrl #(.ADDR_W(ADDR_W), .TRIG_TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .new_sample(new_sample), .sample(sample),
    .vsync(vsync), .capture_en(capture_en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_bank(wr_bank), .rd_bank(rd_bank),
    .frame_swapped(frame_swapped), .state(state)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_addr = 0; m_prev = 0; m_vq = 0;
    m_we = 0; m_bank = 0; m_fs = 0; m_data = 8'h00;
  endtask

  // One clock: drive inputs, advance the model by the same edge, sample 1ns after it.
  task automatic step(input bit ns, input logic [15:0] s, input bit vs, input bit ce);
    bit rise, neg;
    new_sample = ns; sample = s; vsync = vs; capture_en = ce;
    rise = vs && !m_vq;
    neg  = s[15];
    m_we = 0; m_fs = 0;
    if (m_mode == 0) begin
      if (ns && ce) begin
        if ((m_prev && !neg) || m_cnt == TO) begin
          m_mode = 1; m_cnt = 0; m_we = 1; m_addr = 0;
          m_data = {~s[15], s[14:8]};
        end else if (m_cnt < TO) m_cnt++;
      end
    end else if (m_mode == 1) begin
      if (ns) begin
        m_addr++; m_we = 1; m_data = {~s[15], s[14:8]};
        if (m_addr == NB - 1) m_mode = 2;
      end
    end else if (rise) begin
      m_bank = !m_bank; m_fs = 1; m_mode = 0;
    end
    if (ns) m_prev = neg;
    m_vq = vs;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 0; model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wr_en !== 0 || wr_addr !== 0 || wr_bank !== 0 || rd_bank !== 1 || state !== 0 || frame_swapped !== 0 || wr_data !== 0)
      begin errors++; $display("FAIL reset_initial: en=%b addr=%0d wb=%b rb=%b st=%0d", wr_en, wr_addr, wr_bank, rd_bank, state); end
    reset_n = 1;
    step(1, 16'h8000, 0, 1);
    step(1, 16'h0100, 0, 1);
    step(1, 16'h0200, 0, 1);
    checks++;
    if (state !== 2'd1 || wr_addr !== 3'd1)
      begin errors++; $display("FAIL reset_prerun: st=%0d addr=%0d want st=1 addr=1", state, wr_addr); end
    reset_n = 0; model_reset();
    #1;
    checks++;
    if (wr_en !== 0 || wr_addr !== 0 || wr_bank !== 0 || rd_bank !== 1 || state !== 0)
      begin errors++; $display("FAIL reset_async: en=%b addr=%0d wb=%b rb=%b st=%0d", wr_en, wr_addr, wr_bank, rd_bank, state); end
    @(posedge clk); #2;
    reset_n = 1;
    step(0, 16'h0000, 0, 1);
  endtask

  task automatic test_trigger();
    logic [15:0] s;
    step(1, 16'hFFFB, 0, 1);
    checks++; if (wr_en !== 0) begin errors++; $display("FAIL trig_pre1: wr_en=%b want 0", wr_en); end
    step(1, 16'hFFFF, 0, 1);
    checks++; if (wr_en !== 0) begin errors++; $display("FAIL trig_pre2: wr_en=%b want 0", wr_en); end
    step(1, 16'h0100, 0, 1);
    checks++;
    if (wr_en !== 1 || wr_addr !== 0 || wr_data !== 8'h81 || state !== 1)
      begin errors++; $display("FAIL trig_first: en=%b addr=%0d data=%h st=%0d want 1 0 81 1", wr_en, wr_addr, wr_data, state); end
    for (int i = 1; i < NB; i++) begin
      step(0, 16'h0000, 0, 1);
      checks++; if (wr_en !== 0) begin errors++; $display("FAIL trig_pulse%0d: wr_en=%b want 0", i, wr_en); end
      s = 16'h0100 + 16'(i) * 16'h0100;
      step(1, s, 0, 1);
      checks++;
      if (wr_en !== 1 || wr_addr !== 3'(i) || wr_data !== 8'h81 + 8'(i))
        begin errors++; $display("FAIL trig_addr%0d: en=%b addr=%0d data=%h want addr %0d data %h", i, wr_en, wr_addr, wr_data, i, 8'h81 + 8'(i)); end
    end
    checks++; if (state !== 2) begin errors++; $display("FAIL trig_done: state=%0d want 2", state); end
    for (int i = 0; i < 3; i++) begin
      step(1, 16'h8000 ^ 16'(i << 14), 0, 1);
      checks++; if (wr_en !== 0 || wr_addr !== 3'd7) begin errors++; $display("FAIL trig_nowrite%0d: en=%b addr=%0d want 0 7", i, wr_en, wr_addr); end
    end
  endtask

  task automatic test_swap();
    int pulses = 0;
    for (int i = 0; i < 100; i++) begin
      step(0, 16'h0000, 1, 1);
      if (frame_swapped === 1) pulses++;
    end
    step(0, 16'h0000, 0, 1);
    if (frame_swapped === 1) pulses++;
    checks++;
    if (pulses != 1 || wr_bank !== 1 || rd_bank !== 0 || state !== 0)
      begin errors++; $display("FAIL swap: pulses=%0d wb=%b rb=%b st=%0d want 1 1 0 0", pulses, wr_bank, rd_bank, state); end
  endtask

  task automatic test_timeout();
    for (int i = 1; i <= 4; i++) begin
      step(1, 16'h1000, 0, 1);
      checks++; if (wr_en !== 0) begin errors++; $display("FAIL timeout_wait%0d: wr_en=%b want 0", i, wr_en); end
    end
    step(1, 16'h1000, 0, 1);
    checks++;
    if (wr_en !== 1 || wr_addr !== 0 || wr_data !== 8'h90)
      begin errors++; $display("FAIL timeout_fire: en=%b addr=%0d data=%h want 1 0 90", wr_en, wr_addr, wr_data); end
    for (int i = 1; i < NB; i++) step(1, 16'h1000, 0, 1);
    checks++; if (state !== 2) begin errors++; $display("FAIL timeout_done: state=%0d want 2", state); end
  endtask

  task automatic test_vsync_capture();
    step(0, 16'h0000, 1, 1);
    step(0, 16'h0000, 0, 1);
    step(1, 16'h8000, 0, 1);
    step(1, 16'h0400, 0, 1);
    checks++; if (state !== 1 || wr_bank !== 0) begin errors++; $display("FAIL vcap_start: st=%0d wb=%b want 1 0", state, wr_bank); end
    step(0, 16'h0000, 1, 1);
    step(0, 16'h0000, 0, 1);
    checks++; if (frame_swapped !== 0 || state !== 1) begin errors++; $display("FAIL vcap_mid: fs=%b st=%0d want 0 1", frame_swapped, state); end
    for (int i = 1; i < NB - 1; i++) step(1, 16'h0400, 0, 1);
    step(1, 16'h0400, 1, 1);
    checks++;
    if (wr_en !== 1 || wr_addr !== 3'd7 || state !== 2 || frame_swapped !== 0)
      begin errors++; $display("FAIL vcap_last: en=%b addr=%0d st=%0d fs=%b want 1 7 2 0", wr_en, wr_addr, state, frame_swapped); end
    step(0, 16'h0000, 1, 1);
    checks++; if (frame_swapped !== 0 || state !== 2) begin errors++; $display("FAIL vcap_held: fs=%b st=%0d want 0 2", frame_swapped, state); end
    step(0, 16'h0000, 0, 1);
    step(0, 16'h0000, 1, 1);
    checks++;
    if (frame_swapped !== 1 || wr_bank !== 1 || rd_bank !== 0 || state !== 0)
      begin errors++; $display("FAIL vcap_swap: fs=%b wb=%b rb=%b st=%0d want 1 1 0 0", frame_swapped, wr_bank, rd_bank, state); end
    step(0, 16'h0000, 0, 1);
  endtask

  task automatic test_capture_en();
    int writes = 0;
    for (int i = 0; i < 12; i++) begin
      step(1, (i % 2 == 0) ? 16'h8000 : 16'h0100, 0, 0);
      if (wr_en === 1) writes++;
    end
    checks++; if (writes != 0 || state !== 0) begin errors++; $display("FAIL capen_off: writes=%0d st=%0d want 0 0", writes, state); end
    step(1, 16'h8000, 0, 1);
    checks++; if (wr_en !== 0) begin errors++; $display("FAIL capen_neg: wr_en=%b want 0", wr_en); end
    step(1, 16'h0300, 0, 1);
    checks++;
    if (wr_en !== 1 || wr_addr !== 0 || wr_data !== 8'h83 || state !== 1)
      begin errors++; $display("FAIL capen_on: en=%b addr=%0d data=%h st=%0d want 1 0 83 1", wr_en, wr_addr, wr_data, state); end
  endtask

  task automatic test_random();
    bit vs = 0, ce = 1, ns;
    logic [15:0] s;
    for (int c = 0; c < 4000; c++) begin
      ns = ($urandom_range(0, 2) == 0);
      s  = 16'($urandom);
      if ($urandom_range(0, 29) == 0) vs = !vs;
      if ($urandom_range(0, 49) == 0) ce = !ce;
      if (!ce && $urandom_range(0, 3) == 0) ce = 1;
      step(ns, s, vs, ce);
      checks++;
      if (wr_en !== m_we || wr_addr !== 3'(m_addr) || wr_data !== m_data)
        begin errors++; $display("FAIL rand_write c=%0d: en=%b addr=%0d data=%h want %b %0d %h", c, wr_en, wr_addr, wr_data, m_we, m_addr, m_data); end
      checks++;
      if (state !== 2'(m_mode) || wr_bank !== m_bank || rd_bank !== !m_bank || frame_swapped !== m_fs)
        begin errors++; $display("FAIL rand_ctrl c=%0d: st=%0d wb=%b rb=%b fs=%b want %0d %b %b %b", c, state, wr_bank, rd_bank, frame_swapped, m_mode, m_bank, !m_bank, m_fs); end
    end
  endtask

  initial begin
    test_reset();
    test_trigger();
    test_swap();
    test_timeout();
    test_vsync_capture();
    test_capture_en();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
